// File: rtl/wave_composer.sv
// wave_composer: sums NUM_WAVES signed channels plus (seq + offset) through a registered adder tree, applies a ramped gain envelope.
// Define SIGNAL_COMPOSER_SATURATE_EN to clamp the output sample instead of wrapping it.
module wave_composer #(
  parameter int NUM_WAVES  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int RAMP_BITS  = 8
) (
  input  logic                            clk,
  input  logic                            aresetn,
  input  logic [NUM_WAVES*DATA_WIDTH-1:0] wave_in,
  input  logic [NUM_WAVES-1:0]            wave_valid,
  input  logic [DATA_WIDTH-1:0]           offset,
  input  logic [DATA_WIDTH-1:0]           seq,
  input  logic                            dyn_offset_disable,
  input  logic                            disable_dac,
  input  logic [15:0]                     ramp_div,
  output logic [DATA_WIDTH-1:0]           signal_out,
  output logic                            signal_valid,
  output logic                            saturated,
  output logic                            muted,
  output logic                            ramp_busy
);
  localparam int LOG2N = $clog2(NUM_WAVES);
  localparam int TW    = DATA_WIDTH + LOG2N;
  localparam int SW    = TW + 1;
  localparam int PW    = SW + RAMP_BITS;
  localparam int LAT   = LOG2N + 3;
  localparam logic [RAMP_BITS:0] G_TOP = {1'b0, {RAMP_BITS{1'b1}}};

  typedef enum logic [1:0] {MUTED, RAMP_UP, ACTIVE, RAMP_DOWN} state_t;

  logic signed [TW-1:0]     src [LOG2N+1][NUM_WAVES];
  logic signed [TW-1:0]     tree_d [LOG2N][NUM_WAVES];
  logic signed [TW-1:0]     tree_q [LOG2N][NUM_WAVES];
  logic signed [DATA_WIDTH:0] off_d;
  logic signed [DATA_WIDTH:0] off_q [LOG2N];
  logic signed [SW-1:0]     sum_d, sum_q, gain_d, gain_q;
  logic signed [PW-1:0]     prod;
  logic [DATA_WIDTH-1:0]    out_d, out_q;
  logic                     sat_d, sat_q;
  logic [LAT-1:0]           vld_d, vld_q;
  state_t                   state_d, state_q;
  logic [RAMP_BITS:0]       g_d, g_q;
  logic [15:0]              cnt_d, cnt_q;
  logic                     tick, muted_d, muted_q, busy_d, busy_q;

  for (genvar k = 0; k < NUM_WAVES; k++) begin : g_in
    assign src[0][k] = TW'($signed(wave_in[k*DATA_WIDTH +: DATA_WIDTH]));
  end

  // Every level keeps the full final width, so the pairwise sums never overflow.
  for (genvar l = 0; l < LOG2N; l++) begin : g_lvl
    for (genvar k = 0; k < NUM_WAVES; k++) begin : g_node
      assign src[l+1][k] = tree_q[l][k];
      if (k < (NUM_WAVES >> (l + 1))) begin : g_add
        assign tree_d[l][k] = src[l][2*k] + src[l][2*k+1];
      end else begin : g_zero
        assign tree_d[l][k] = '0;
      end
    end
  end

  always_comb begin
    off_d  = dyn_offset_disable ? '0 : (DATA_WIDTH+1)'($signed(seq)) + (DATA_WIDTH+1)'($signed(offset));
    sum_d  = SW'(src[LOG2N][0]) + SW'(off_q[LOG2N-1]);
    prod   = PW'(sum_q) * PW'($signed({1'b0, g_q}));
    gain_d = prod[RAMP_BITS +: SW];
    vld_d  = {vld_q[LAT-2:0], &wave_valid};
  end

`ifdef SIGNAL_COMPOSER_SATURATE_EN
  logic ovf;
  always_comb begin
    ovf   = !(&gain_q[SW-1:DATA_WIDTH-1] || !(|gain_q[SW-1:DATA_WIDTH-1]));
    out_d = ovf ? {gain_q[SW-1], {(DATA_WIDTH-1){~gain_q[SW-1]}}} : gain_q[DATA_WIDTH-1:0];
    sat_d = ovf;
  end
`else
  always_comb begin
    out_d = gain_q[DATA_WIDTH-1:0];
    sat_d = 1'b0;
  end
`endif

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    cnt_d   = '0;
    tick    = cnt_q >= ramp_div;
    case (state_q)
      MUTED:   if (!disable_dac) state_d = RAMP_UP;
      ACTIVE:  if (disable_dac) state_d = RAMP_DOWN;
      RAMP_UP: begin
        if (disable_dac) state_d = RAMP_DOWN;
        else if (tick) begin
          g_d     = g_q + 1'b1;
          state_d = (g_q == G_TOP) ? ACTIVE : RAMP_UP;
        end else cnt_d = cnt_q + 16'd1;
      end
      default: begin
        if (!disable_dac) state_d = RAMP_UP;
        else if (tick) begin
          g_d     = g_q - 1'b1;
          state_d = (g_q == 1) ? MUTED : RAMP_DOWN;
        end else cnt_d = cnt_q + 16'd1;
      end
    endcase
    muted_d = state_d == MUTED;
    busy_d  = state_d == RAMP_UP || state_d == RAMP_DOWN;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int l = 0; l < LOG2N; l++) begin
        off_q[l] <= '0;
        for (int k = 0; k < NUM_WAVES; k++) tree_q[l][k] <= '0;
      end
      sum_q   <= '0;
      gain_q  <= '0;
      out_q   <= '0;
      sat_q   <= 1'b0;
      vld_q   <= '0;
      state_q <= MUTED;
      g_q     <= '0;
      cnt_q   <= '0;
      muted_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      off_q[0] <= off_d;
      for (int l = 1; l < LOG2N; l++) off_q[l] <= off_q[l-1];
      for (int l = 0; l < LOG2N; l++)
        for (int k = 0; k < NUM_WAVES; k++) tree_q[l][k] <= tree_d[l][k];
      sum_q   <= sum_d;
      gain_q  <= gain_d;
      out_q   <= out_d;
      sat_q   <= sat_d;
      vld_q   <= vld_d;
      state_q <= state_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
      muted_q <= muted_d;
      busy_q  <= busy_d;
    end
  end

  assign signal_out   = out_q;
  assign signal_valid = vld_q[LAT-1];
  assign saturated    = sat_q;
  assign muted        = muted_q;
  assign ramp_busy    = busy_q;
endmodule

// File: tb/tb_wave_composer.sv
// tb_wave_composer: random and directed stimulus for wave_composer against a cycle-level arithmetic model.
module tb_wave_composer;
  logic               clk = 1'b0;
  logic               aresetn = 1'b0;
  logic [63:0]        wave_in;
  logic [3:0]         wave_valid;
  logic signed [15:0] offset, seq;
  logic               dyn_offset_disable, disable_dac;
  logic [15:0]        ramp_div;
  logic signed [15:0] signal_out;
  logic               signal_valid, saturated, muted, ramp_busy;

  int errors = 0, checks = 0;
  int cyc, mg, dir, cnt;
  bit m_muted, m_busy;
  longint s_h [8];
  bit     v_h [8];
  int     g_h [8];

`ifdef SIGNAL_COMPOSER_SATURATE_EN
  localparam longint POS_EXP = 32767, NEG_EXP = -32768, SAT_EXP = 1;
`else
  localparam longint POS_EXP = -1536, NEG_EXP = 1536, SAT_EXP = 0;
`endif

  wave_composer dut (
    .clk(clk), .aresetn(aresetn), .wave_in(wave_in), .wave_valid(wave_valid),
    .offset(offset), .seq(seq), .dyn_offset_disable(dyn_offset_disable),
    .disable_dac(disable_dac), .ramp_div(ramp_div), .signal_out(signal_out),
    .signal_valid(signal_valid), .saturated(saturated), .muted(muted), .ramp_busy(ramp_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic longint reduce(input longint p, output bit sat);
`ifdef SIGNAL_COMPOSER_SATURATE_EN
    sat = (p > 32767) || (p < -32768);
    return p > 32767 ? 32767 : (p < -32768 ? -32768 : p);
`else
    logic [63:0] b;
    b = p;
    sat = 1'b0;
    return longint'($signed(b[15:0]));
`endif
  endfunction

  task automatic set_waves(input int a, input int b, input int c, input int d);
    wave_in = {16'(d), 16'(c), 16'(b), 16'(a)};
  endtask

  task automatic rand_data(input bit wide);
    for (int k = 0; k < 4; k++)
      wave_in[k*16 +: 16] = wide ? 16'($urandom) : 16'($urandom_range(0, 16000) - 8000);
    seq    = wide ? 16'($urandom) : 16'($urandom_range(0, 2000) - 1000);
    offset = wide ? 16'($urandom) : 16'($urandom_range(0, 2000) - 1000);
    dyn_offset_disable = $urandom_range(0, 3) == 0;
    wave_valid = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hf;
  endtask

  // One clock: record this cycle's inputs and gain, advance the envelope, then check after the edge.
  task automatic step();
    longint s, e;
    bit es;
    int want;
    bit rest;
    s = 0;
    for (int k = 0; k < 4; k++) s += longint'($signed(wave_in[k*16 +: 16]));
    if (!dyn_offset_disable) s += longint'(seq) + longint'(offset);
    s_h[cyc & 7] = s;
    v_h[cyc & 7] = &wave_valid;
    g_h[cyc & 7] = mg;
    want = disable_dac ? -1 : 1;
    rest = (dir == 0) && ((want > 0 && mg == 256) || (want < 0 && mg == 0));
    if (dir != want && !rest) begin
      dir = want;
      cnt = 0;
    end else if (dir != 0) begin
      if (cnt >= int'(ramp_div)) begin
        mg += dir;
        cnt = 0;
        if (mg == 0 || mg == 256) dir = 0;
      end else cnt++;
    end
    m_muted = dir == 0 && mg == 0;
    m_busy  = dir != 0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    es = 1'b0;
    e  = (cyc >= 5) ? reduce((s_h[(cyc-5) & 7] * g_h[(cyc-2) & 7]) >>> 8, es) : 0;
    check("out", signal_out, e);
    check("valid", signal_valid, (cyc >= 5) ? v_h[(cyc-5) & 7] : 0);
    check("sat", saturated, es);
    check("muted", muted, m_muted);
    check("busy", ramp_busy, m_busy);
  endtask

  task automatic do_reset();
    #2 aresetn = 1'b0;
    #1;
    check("rst_out", signal_out, 0);
    check("rst_valid", signal_valid, 0);
    check("rst_sat", saturated, 0);
    check("rst_muted", muted, 1);
    check("rst_busy", ramp_busy, 0);
    mg = 0; dir = 0; cnt = 0; cyc = 0;
    m_muted = 1'b1; m_busy = 1'b0;
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    set_waves(0, 0, 0, 0);
    wave_valid = 4'hf; seq = 0; offset = 0;
    dyn_offset_disable = 1'b0; disable_dac = 1'b0; ramp_div = 16'd0;
    @(negedge clk);
    do_reset();
    repeat (270) begin rand_data(1'b0); step(); end
    set_waves(1000, 2000, 3000, 4000);
    seq = 50; offset = 100; dyn_offset_disable = 1'b0; wave_valid = 4'hf;
    repeat (5) step();
    check("steady", signal_out, 10150);
    check("steady_valid", signal_valid, 1);
    dyn_offset_disable = 1'b1;
    repeat (5) step();
    check("no_offset", signal_out, 10000);
    set_waves(16000, 16000, 16000, 16000);
    repeat (5) step();
    check("big_pos", signal_out, POS_EXP);
    check("big_pos_flag", saturated, SAT_EXP);
    set_waves(-16000, -16000, -16000, -16000);
    repeat (5) step();
    check("big_neg", signal_out, NEG_EXP);
    check("big_neg_flag", saturated, SAT_EXP);
    repeat (800) begin
      rand_data(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 59) == 0) disable_dac = ~disable_dac;
      if ($urandom_range(0, 99) == 0) ramp_div = 16'($urandom_range(0, 3));
      step();
    end
    disable_dac = 1'b0; ramp_div = 16'd0;
    do_reset();
    ramp_div = 16'd3;
    for (int i = 0; i < 1200 && mg != 100; i++) begin rand_data(1'b0); step(); end
    disable_dac = 1'b1;
    repeat (400) begin rand_data(1'b0); step(); end
    check("rev_still_busy", ramp_busy, 1);
    step();
    check("rev_muted", muted, 1);
    check("rev_idle", ramp_busy, 0);
    disable_dac = 1'b0; ramp_div = 16'd0;
    repeat (260) begin rand_data(1'b0); wave_valid = 4'hf; step(); end
    wave_valid = 4'b1011;
    step();
    wave_valid = 4'hf;
    repeat (4) step();
    check("vdrop_low", signal_valid, 0);
    step();
    check("vdrop_back", signal_valid, 1);
    disable_dac = 1'b1;
    for (int i = 0; i < 400 && mg != 60; i++) begin rand_data(1'b0); step(); end
    disable_dac = 1'b0;
    set_waves(6400, 6400, 6400, 6400);
    dyn_offset_disable = 1'b1; wave_valid = 4'hf;
    do_reset();
    repeat (10) step();
    check("restart", signal_out, 700);
    repeat (121) step();
    check("half_gain", signal_out, 12800);
    repeat (140) step();
    check("full_gain", signal_out, 25600);
    check("full_idle", ramp_busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wave_composer.md
# wave_composer

Parametrised successor to the four-channel DAC signal composer. It sums NUM_WAVES signed waveform channels and an optional dynamic offset (seq + offset) through a registered adder tree. It applies a ramped gain envelope so DAC enable and disable fade in and out instead of stepping, and it registers a width-reduced, optionally saturated DAC sample. It sits between the per-channel waveform generators and the DAC output formatter, one instance per DAC channel.

## Interface
- NUM_WAVES, 4, channel count; power of two, 2..16.
- DATA_WIDTH, 16, sample width of inputs and output, signed two's complement.
- RAMP_BITS, 8, gain resolution; full-scale gain G_MAX = 2^RAMP_BITS.
- LOG2N (derived), log2(NUM_WAVES).
- clk  in  1  system clock; all logic on the rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- wave_in  in  NUM_WAVES*DATA_WIDTH  packed channels; channel k at [k*DATA_WIDTH +: DATA_WIDTH], signed.
- wave_valid  in  NUM_WAVES  per-channel valid.
- offset  in  DATA_WIDTH  signed static offset.
- seq  in  DATA_WIDTH  signed sequence value.
- dyn_offset_disable  in  1  forces the (seq + offset) term to 0.
- disable_dac  in  1  mute request; muting is ramped.
- ramp_div  in  16  gain step prescaler; one gain step every ramp_div+1 cycles.
- signal_out  out  DATA_WIDTH  composed sample, signed.
- signal_valid  out  1  AND of all wave_valid, latency-aligned.
- saturated  out  1  the current signal_out was clamped.
- muted  out  1  envelope state is MUTED.
- ramp_busy  out  1  envelope state is RAMP_UP or RAMP_DOWN.

## Operation
- Adder tree has LOG2N registered levels. Each level adds adjacent pairs and widens by 1 bit, so nothing is lost: final width DATA_WIDTH+LOG2N.
- Offset term: seq + offset at DATA_WIDTH+1 bits, or 0 if dyn_offset_disable. It is sampled in the same cycle as wave_in and delayed to align with the tree output.
- Combine stage, registered: sum = tree + offset term, sign-extended to DATA_WIDTH+LOG2N+1 bits.
- Gain stage, registered: prod = sum * g, where g is the unsigned gain register in 0..G_MAX. The result is sum * g, arithmetic-shifted right by RAMP_BITS, so it rounds toward minus infinity. At g=G_MAX the output equals sum exactly.
- Output stage, registered: the result is reduced to DATA_WIDTH bits (see Configuration).
- signal_valid is the AND of all wave_valid bits, delayed through a shift register of equal latency.
- Envelope FSM:
  - States: MUTED (g=0), RAMP_UP, ACTIVE (g=G_MAX), RAMP_DOWN.
  - MUTED -> RAMP_UP when disable_dac=0.
  - RAMP_UP: g+=1 per tick; on reaching G_MAX -> ACTIVE; disable_dac=1 -> RAMP_DOWN from the current g, no jump.
  - ACTIVE -> RAMP_DOWN when disable_dac=1.
  - RAMP_DOWN: g-=1 per tick; on reaching 0 -> MUTED; disable_dac=0 -> RAMP_UP from the current g.
  - Tick: the prescaler counter increments each cycle and ticks when count >= ramp_div, then clears.
  - The counter clears on every state change.
  - If ramp_div is lowered mid-ramp below the current count, the tick fires on the next cycle.
- Full ramp duration is G_MAX*(ramp_div+1) cycles.
- g is never outside 0..G_MAX.
- The data path ignores valid: samples with signal_valid=0 still propagate.

## Timing
- Latency from wave_in/seq/offset/dyn_offset_disable to signal_out and signal_valid is LOG2N+3 cycles (5 for NUM_WAVES=4).
- A gain change in cycle n affects the sample in the gain stage in cycle n+1 and appears at signal_out one cycle later.
- muted and ramp_busy are registered state decodes, valid in the cycle after a transition.
- Reset (asynchronous, immediate):
  - signal_out=0, signal_valid=0, saturated=0.
  - All pipeline and valid registers cleared.
  - State MUTED, g=0, prescaler 0.
  - muted=1, ramp_busy=0.
- After aresetn deasserts, signal_valid stays 0 for at least LOG2N+3 cycles.
- Reset mid-ramp aborts the ramp; there is no resume.

## Configuration
- SIGNAL_COMPOSER_SATURATE_EN defined:
  - The gain-stage result is clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - saturated=1 in the cycle the clamped value is on signal_out.
- SIGNAL_COMPOSER_SATURATE_EN undefined:
  - The low DATA_WIDTH bits are taken (two's-complement wrap, legacy behaviour).
  - saturated is tied to 0.

## Test plan
All scenarios use NUM_WAVES=4, DATA_WIDTH=16, RAMP_BITS=8, ramp_div=0.
1. Steady state: after reset release with disable_dac=0, wait past 256 cycles until ACTIVE. Drive waves 1000/2000/3000/4000, seq=50, offset=100, all valid -> signal_out=10150 five cycles later; signal_valid=1. Then dyn_offset_disable=1 -> 10000 five cycles later.
2. Ramp-up profile: waves 6400 each (sum 25600), offset term 0, released from reset -> signal_out rises in steps of 100; it reads 12800 when g=128 and 25600 at ACTIVE. ramp_busy=1 during the ramp; muted falls one cycle after reset release.
3. Saturation, macro defined: waves +16000 each -> 32767 with saturated=1; waves -16000 each -> -32768 with saturated=1. Macro undefined: +16000 each -> -1536, saturated=0.
4. Ramp reversal: ramp_div=3; assert disable_dac when g=100 during RAMP_UP -> g decrements once every 4 cycles, reaches 0 after 400 cycles, then muted=1 and ramp_busy=0.
5. Valid alignment: drop wave_valid[2] for one cycle in ACTIVE -> signal_valid low for exactly one cycle, 5 cycles later; signal_out data unaffected.
6. Reset mid-ramp: pulse aresetn low at g=60 -> all outputs 0 and muted=1 immediately. After release with disable_dac=0, the ramp restarts from g=0.
